mc_control: RTL and testbench

- Multicycle control sequencer for the MIPS datapath.
- Breaks each instruction into FETCH/DECODE/EXEC/MEM/WB states. Drives the datapath control lines (RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Jump, Jal, Jr) plus ir_write and pc_write.
- Inputs are the OpCode/funct fields returned by the datapath and a data-memory ready handshake.
- Counts retired instructions and traps on illegal opcodes.

---
 rtl/mc_control_if.sv | 37 +++
 rtl/mc_control.sv | 181 ++++++++++++++++++
 tb/tb_mc_control.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Bundle of instruction fields, memory handshake and control lines between
// the multicycle sequencer (master) and the MIPS datapath (slave).
interface mc_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       OpCode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             ir_write;
  logic             pc_write;
  logic             RegDst;
  logic             AluSrc;
  logic             MemtoReg;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             Branch;
  logic             Jump;
  logic             Jal;
  logic             Jr;
  logic [1:0]       ALUOp;
  logic [2:0]       state_o;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  OpCode, funct, mem_ready,
    output ir_write, pc_write, RegDst, AluSrc, MemtoReg, RegWrite, MemRead,
           MemWrite, Branch, Jump, Jal, Jr, ALUOp, state_o, halted, retired
  );

  modport slave (
    output OpCode, funct, mem_ready,
    input  ir_write, pc_write, RegDst, AluSrc, MemtoReg, RegWrite, MemRead,
           MemWrite, Branch, Jump, Jal, Jr, ALUOp, state_o, halted, retired
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with a trap on
// illegal opcodes and a retired-instruction counter.
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic       ir_write, pc_write, reg_dst, alu_src, mem_to_reg, reg_write;
  logic       mem_read, mem_write, branch, jump, jal, jr, halted;
  logic [1:0] alu_op;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    funct_d    = funct_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    jal        = 1'b0;
    jr         = 1'b0;
    halted     = 1'b0;
    alu_op     = 2'b00;

    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        op_d    = bus.OpCode;
        funct_d = bus.funct;
        case (bus.OpCode)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL: state_d = S_EXEC;
          default: state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_RTYPE: begin
            if (funct_q == FN_JR) begin
              jump     = 1'b1;
              jr       = 1'b1;
              pc_write = 1'b1;
              state_d  = S_FETCH;
            end else begin
              alu_op  = 2'b10;
              reg_dst = 1'b1;
              state_d = S_WB;
            end
          end
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            branch   = 1'b1;
            alu_op   = 2'b01;
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          OP_ADDI: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          OP_J: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          OP_JAL: begin
            jump      = 1'b1;
            jal       = 1'b1;
            reg_write = 1'b1;
            pc_write  = 1'b1;
            state_d   = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        // Only lw and sw ever reach MEM, so anything that is not lw is a store.
        alu_src = 1'b1;
        if (op_q == OP_LW) mem_read = 1'b1;
        else mem_write = 1'b1;
        if (bus.mem_ready) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
        case (op_q)
          OP_RTYPE: begin
            reg_dst = 1'b1;
            alu_op  = 2'b10;
          end
          OP_ADDI: alu_src = 1'b1;
          OP_LW: begin
            mem_to_reg = 1'b1;
            alu_src    = 1'b1;
          end
          default: ;
        endcase
      end
      S_TRAP: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase

    retired_d = retired_q + CNT_W'(pc_write);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      retired_q <= retired_d;
    end
  end

  // Reset forces every control line low immediately, whatever state is held.
  assign bus.ir_write = ir_write   & ~reset;
  assign bus.pc_write = pc_write   & ~reset;
  assign bus.RegDst   = reg_dst    & ~reset;
  assign bus.AluSrc   = alu_src    & ~reset;
  assign bus.MemtoReg = mem_to_reg & ~reset;
  assign bus.RegWrite = reg_write  & ~reset;
  assign bus.MemRead  = mem_read   & ~reset;
  assign bus.MemWrite = mem_write  & ~reset;
  assign bus.Branch   = branch     & ~reset;
  assign bus.Jump     = jump       & ~reset;
  assign bus.Jal      = jal        & ~reset;
  assign bus.Jr       = jr         & ~reset;
  assign bus.halted   = halted     & ~reset;
  assign bus.ALUOp    = reset ? 2'b00 : alu_op;
  assign bus.state_o  = reset ? 3'd0 : state_q;
  assign bus.retired  = retired_q;
endmodule

// File: tb/tb_mc_control.sv
// Cycle-by-cycle vector bench for mc_control: expected state, control lines
// and retired count per cycle flow through a scoreboard queue.
module tb_mc_control;
  localparam int CNT_W = 32;

  localparam logic [14:0] C_IRW  = 15'h4000;
  localparam logic [14:0] C_PCW  = 15'h2000;
  localparam logic [14:0] C_RD   = 15'h1000;
  localparam logic [14:0] C_AS   = 15'h0800;
  localparam logic [14:0] C_M2R  = 15'h0400;
  localparam logic [14:0] C_RW   = 15'h0200;
  localparam logic [14:0] C_MR   = 15'h0100;
  localparam logic [14:0] C_MW   = 15'h0080;
  localparam logic [14:0] C_BR   = 15'h0040;
  localparam logic [14:0] C_J    = 15'h0020;
  localparam logic [14:0] C_JAL  = 15'h0010;
  localparam logic [14:0] C_JR   = 15'h0008;
  localparam logic [14:0] C_FN   = 15'h0004;
  localparam logic [14:0] C_SUB  = 15'h0002;
  localparam logic [14:0] C_HALT = 15'h0001;

  localparam logic [5:0] JUNK_OP = 6'h3F;
  localparam logic [5:0] JUNK_FN = 6'h08;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        mr;
    logic [2:0]  st;
    logic [14:0] ctrl;
    logic [31:0] ret;
  } vec_t;

  typedef struct {
    int          idx;
    logic [2:0]  st;
    logic [14:0] ctrl;
    logic [31:0] ret;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  vec_t vecs[$];
  exp_t exp_q[$];

  mc_control_if #(.CNT_W(CNT_W)) bus ();

  mc_control #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addv(logic rst, logic [5:0] op, logic [5:0] fn, logic mr,
                               logic [2:0] st, logic [14:0] ctrl, int ret);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.mr = mr;
    v.st = st; v.ctrl = ctrl; v.ret = 32'(ret);
    vecs.push_back(v);
  endfunction

  // FETCH then DECODE of an instruction; junk fields are driven outside DECODE
  function automatic void fetchDecode(logic [5:0] op, logic [5:0] fn, int ret);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd0, C_IRW, ret);
    addv(0, op, fn, 1, 3'd1, 15'h0, ret);
  endfunction

  function automatic void buildTable();
    // add
    fetchDecode(6'b000000, 6'b100000, 0);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd2, C_RD | C_FN, 0);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd4, C_RW | C_PCW | C_RD | C_FN, 0);
    // lw with three wait cycles
    fetchDecode(6'b100011, 6'h00, 1);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd2, C_AS, 1);
    for (int i = 0; i < 3; i++) addv(0, JUNK_OP, JUNK_FN, 0, 3'd3, C_AS | C_MR, 1);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd3, C_AS | C_MR, 1);
    addv(0, JUNK_OP, JUNK_FN, 0, 3'd4, C_RW | C_PCW | C_M2R | C_AS, 1);
    // sw, memory ready at once
    fetchDecode(6'b101011, 6'h00, 2);
    addv(0, JUNK_OP, JUNK_FN, 0, 3'd2, C_AS, 2);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd3, C_AS | C_MW | C_PCW, 2);
    // beq, j, jal, jr back to back
    fetchDecode(6'b000100, 6'h00, 3);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd2, C_BR | C_SUB | C_PCW, 3);
    fetchDecode(6'b000010, 6'h00, 4);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd2, C_J | C_PCW, 4);
    fetchDecode(6'b000011, 6'h00, 5);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd2, C_J | C_JAL | C_RW | C_PCW, 5);
    fetchDecode(6'b000000, 6'b001000, 6);
    addv(0, JUNK_OP, 6'b100000, 1, 3'd2, C_J | C_JR | C_PCW, 6);
    // addi
    fetchDecode(6'b001000, 6'h00, 7);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd2, C_AS, 7);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd4, C_RW | C_PCW | C_AS, 7);
    // reset while lw waits in MEM
    fetchDecode(6'b100011, 6'h00, 8);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd2, C_AS, 8);
    addv(0, JUNK_OP, JUNK_FN, 0, 3'd3, C_AS | C_MR, 8);
    addv(1, JUNK_OP, JUNK_FN, 0, 3'd0, 15'h0, 8);
    // addi right after that reset
    fetchDecode(6'b001000, 6'h00, 0);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd2, C_AS, 0);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd4, C_RW | C_PCW | C_AS, 0);
    // illegal opcode traps; mem_ready toggling has no effect
    fetchDecode(6'b111111, 6'h00, 1);
    for (int i = 0; i < 20; i++) addv(0, JUNK_OP, JUNK_FN, logic'(i % 2), 3'd7, C_HALT, 1);
    addv(1, JUNK_OP, JUNK_FN, 1, 3'd0, 15'h0, 1);
    addv(0, JUNK_OP, JUNK_FN, 1, 3'd0, C_IRW, 0);
  endfunction

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    reset         = v.rst;
    bus.OpCode    = v.op;
    bus.funct     = v.fn;
    bus.mem_ready = v.mr;
    e.idx = idx; e.st = v.st; e.ctrl = v.ctrl; e.ret = v.ret;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [14:0] act;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL scoreboard: actual=empty required=entry");
      return;
    end
    e = exp_q.pop_front();
    act = {bus.ir_write, bus.pc_write, bus.RegDst, bus.AluSrc, bus.MemtoReg,
           bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Branch, bus.Jump,
           bus.Jal, bus.Jr, bus.ALUOp, bus.halted};
    checks++;
    if (bus.state_o !== e.st) begin
      fails++;
      $display("[TB] FAIL state_o cycle %0d: actual=%0d required=%0d", e.idx, bus.state_o, e.st);
    end
    checks++;
    if (act !== e.ctrl) begin
      fails++;
      $display("[TB] FAIL controls cycle %0d: actual=%015b required=%015b", e.idx, act, e.ctrl);
    end
    checks++;
    if (bus.retired !== e.ret) begin
      fails++;
      $display("[TB] FAIL retired cycle %0d: actual=%0d required=%0d", e.idx, bus.retired, e.ret);
    end
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    reset         = 1'b1;
    bus.OpCode    = 6'd0;
    bus.funct     = 6'd0;
    bus.mem_ready = 1'b0;
    buildTable();
    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i], i);
      #1;
      checkOutput();
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
